// File: rtl/ftdi_fifo_burst_wr.sv
// Buffered burst writer for an FT245-style async FIFO: bytes are queued internally
// and drained one per write cycle while TXE# allows, with parameterised bus timing.
module ftdi_fifo_burst_wr #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int GAP_CYC    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iWR_EN_n,
    input  logic [DATA_W-1:0]     iWR_DATA,
    output logic                  oFULL_n,
    output logic                  oEMPTY_n,
    output logic [DEPTH_LOG2:0]   oLEVEL,
    output logic                  oOVF,
    output logic                  oRUN_WR_n,
    output logic                  oDONE_WR_n,
    input  logic                  iFIFO_TXE_n,
    output logic                  oFIFO_WR,
    output logic [DATA_W-1:0]     oFIFO_DATA,
    output logic                  oFIFO_OE
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Counter reload values: a state with N cycles loads N-1 and exits at zero.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] GAP_LD    = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP
    } state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  txe_meta;
    logic                  txe_s;
    state_t                state;
    logic [7:0]            cnt;
    logic                  pop;
    logic                  push;

    // A pop frees a slot in the same cycle, so a full buffer still accepts a push then.
    assign pop  = (state == IDLE) && (count != '0) && !txe_s;
    assign push = !iWR_EN_n && ((count != FULL_LVL) || pop);

    assign oFULL_n  = (count != FULL_LVL);
    assign oEMPTY_n = (count != '0);
    assign oLEVEL   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            txe_meta <= iFIFO_TXE_n;
            txe_s    <= txe_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            oOVF   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (!iWR_EN_n && !push) oOVF <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= iWR_DATA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            oRUN_WR_n  <= 1'b1;
            oDONE_WR_n <= 1'b1;
            oFIFO_WR   <= 1'b0;
            oFIFO_DATA <= '0;
            oFIFO_OE   <= 1'b0;
        end else begin
            oDONE_WR_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= SETUP;
                        cnt        <= SETUP_LD;
                        oFIFO_DATA <= mem[rd_ptr];
                        oFIFO_OE   <= 1'b1;
                        oRUN_WR_n  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        state    <= STROBE;
                        cnt      <= STROBE_LD;
                        oFIFO_WR <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        state      <= HOLD;
                        cnt        <= HOLD_LD;
                        oFIFO_WR   <= 1'b0;
                        oDONE_WR_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state    <= GAP;
                        cnt      <= GAP_LD;
                        oFIFO_OE <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: begin
                    // TXE# is looked at again only once back in IDLE.
                    if (cnt == 8'd0) begin
                        state     <= IDLE;
                        oRUN_WR_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    oRUN_WR_n <= 1'b1;
                    oFIFO_WR  <= 1'b0;
                    oFIFO_OE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ftdi_fifo_burst_wr.sv
// Bench for ftdi_fifo_burst_wr: a queue-and-timeline reference model predicts every
// output each cycle; scenario tasks add directed timing and ordering checks.
module tb_ftdi_fifo_burst_wr;

    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int GAP_CYC    = 3;
    localparam int PERIOD     = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC + GAP_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en_n = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       txe_n = 1'b1;
    logic       full_n, empty_n, ovf, run_n, done_n, fifo_wr, fifo_oe;
    logic [4:0] level;
    logic [7:0] fifo_data;

    ftdi_fifo_burst_wr #(
        .DATA_W(8), .DEPTH_LOG2(DEPTH_LOG2), .SETUP_CYC(SETUP_CYC),
        .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk), .rst(rst), .iWR_EN_n(wr_en_n), .iWR_DATA(wr_data),
        .oFULL_n(full_n), .oEMPTY_n(empty_n), .oLEVEL(level), .oOVF(ovf),
        .oRUN_WR_n(run_n), .oDONE_WR_n(done_n), .iFIFO_TXE_n(txe_n),
        .oFIFO_WR(fifo_wr), .oFIFO_DATA(fifo_data), .oFIFO_OE(fifo_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: buffer contents as a queue, write timing as offsets from the pop edge.
    logic [7:0] q[$];
    int         cyc = 0;
    int         last_pop = -1000;
    int         idle_from = 0;
    logic [7:0] last_byte = 8'h00;
    logic       s1 = 1'b1, s2 = 1'b1;
    logic       ovf_m = 1'b0;

    int   rises[$];
    logic [7:0] sent[$];
    logic prev_wr = 1'b0;

    task automatic model_reset();
        q.delete();
        last_pop  = -1000;
        idle_from = 0;
        last_byte = 8'h00;
        s1 = 1'b1;
        s2 = 1'b1;
        ovf_m = 1'b0;
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        cyc++;
        do_pop  = (cyc >= idle_from) && (q.size() > 0) && (s2 == 1'b0);
        do_push = !wr_en_n && ((q.size() < DEPTH) || do_pop);
        if (!wr_en_n && !do_push) ovf_m = 1'b1;
        if (do_pop) begin
            last_byte = q.pop_front();
            last_pop  = cyc;
            idle_from = cyc + PERIOD;
        end
        if (do_push) q.push_back(wr_data);
        s2 = s1;
        s1 = txe_n;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst) model_step();
        @(negedge clk);
        if (fifo_wr && !prev_wr) rises.push_back(edge_n);
        if (!fifo_wr && prev_wr) sent.push_back(fifo_data);
        prev_wr = fifo_wr;
    endtask

    function automatic logic [19:0] dut_vec();
        return {full_n, empty_n, level, ovf, run_n, done_n, fifo_wr, fifo_data, fifo_oe};
    endfunction

    function automatic logic [19:0] exp_vec();
        int k;
        logic oe, wr;
        k  = cyc - last_pop;
        oe = (k >= 0) && (k < SETUP_CYC + STROBE_CYC + HOLD_CYC);
        wr = (k >= SETUP_CYC) && (k < SETUP_CYC + STROBE_CYC);
        return {q.size() != DEPTH, q.size() != 0, 5'(q.size()), ovf_m,
                !((k >= 0) && (k < PERIOD - 1)), !(k == SETUP_CYC + STROBE_CYC),
                wr, last_byte, oe};
    endfunction

    task automatic apply_reset();
        wr_en_n = 1'b1;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        rises.delete();
        sent.delete();
        prev_wr = 1'b0;
    endtask

    task automatic test_reset();
        txe_n = 1'b1;
        rst = 1'b1;
        model_reset();
        tick();
        checks++;
        if (dut_vec() !== 20'b1_0_00000_0_1_1_0_00000000_0) begin
            errors++;
            $display("FAIL reset_values actual=%b required=%b", dut_vec(), 20'b1_0_00000_0_1_1_0_00000000_0);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single();
        int push_edge;
        apply_reset();
        txe_n = 1'b0;
        repeat (3) tick();
        rises.delete();
        wr_en_n = 1'b0;
        wr_data = 8'hA5;
        tick();
        push_edge = edge_n;
        wr_en_n = 1'b1;
        repeat (12) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (rises.size() != 1 || rises[0] - push_edge != 2) begin
            errors++;
            $display("FAIL single_wr_latency actual=%0d required=2", rises.size() ? rises[0] - push_edge : -1);
        end
        checks++;
        if (sent.size() != 1 || sent[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte actual=%h required=a5", sent.size() ? sent[0] : 8'hxx);
        end
    endtask

    task automatic test_burst();
        apply_reset();
        txe_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            wr_en_n = 1'b0;
            wr_data = 8'(i);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst_push edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        wr_en_n = 1'b1;
        repeat (140) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst_drain edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (sent.size() != 16) begin
            errors++;
            $display("FAIL burst_count actual=%0d required=16", sent.size());
        end
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            checks++;
            if (sent[i] !== 8'(i)) begin
                errors++;
                $display("FAIL burst_order idx=%0d actual=%h required=%h", i, sent[i], 8'(i));
            end
        end
        for (int i = 1; i < rises.size(); i++) begin
            checks++;
            if (rises[i] - rises[i-1] != PERIOD) begin
                errors++;
                $display("FAIL burst_spacing idx=%0d actual=%0d required=%0d", i, rises[i] - rises[i-1], PERIOD);
            end
        end
        checks++;
        if (level !== 5'd0 || empty_n !== 1'b0) begin
            errors++;
            $display("FAIL burst_end_level actual=%0d/%b required=0/0", level, empty_n);
        end
    endtask

    task automatic test_overflow();
        int   rel;
        logic saw55;
        logic [7:0] b;
        apply_reset();
        txe_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h55) b = 8'h54;
            wr_en_n = 1'b0;
            wr_data = b;
            tick();
        end
        wr_data = 8'h55;
        tick();
        wr_en_n = 1'b1;
        checks++;
        if (full_n !== 1'b0 || level !== 5'd16 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flags actual=full_n%b lvl%0d ovf%b required=full_n0 lvl16 ovf1", full_n, level, ovf);
        end
        rises.delete();
        rel = edge_n;
        txe_n = 1'b0;
        saw55 = 1'b0;
        repeat (140) begin
            tick();
            if (fifo_data == 8'h55) saw55 = 1'b1;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ovf_drain edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (rises.size() != 16 || rises[0] - rel != 4) begin
            errors++;
            $display("FAIL ovf_release actual=%0d pulses first@%0d required=16 pulses first@4",
                     rises.size(), rises.size() ? rises[0] - rel : -1);
        end
        checks++;
        if (saw55) begin
            errors++;
            $display("FAIL ovf_dropped_byte actual=55_on_bus required=never");
        end
    endtask

    task automatic test_back_pressure();
        int n;
        apply_reset();
        txe_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            wr_en_n = 1'b0;
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        wr_en_n = 1'b1;
        n = 0;
        while (rises.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (rises.size() < 3) begin
            errors++;
            $display("FAIL bp_wait actual=%0d pulses required=3", rises.size());
        end
        txe_n = 1'b1;
        repeat (25) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_park edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (run_n !== 1'b1 || rises.size() != 3 || level !== 5'd2) begin
            errors++;
            $display("FAIL bp_parked actual=run_n%b pulses%0d lvl%0d required=run_n1 pulses3 lvl2", run_n, rises.size(), level);
        end
        txe_n = 1'b0;
        repeat (30) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL bp_resume edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (rises.size() != 5) begin
            errors++;
            $display("FAIL bp_total actual=%0d required=5", rises.size());
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        txe_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            wr_en_n = 1'b0;
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        wr_en_n = 1'b1;
        txe_n = 1'b0;
        tick();
        tick();
        wr_en_n = 1'b0;
        wr_data = 8'h3C;
        tick();
        wr_en_n = 1'b1;
        checks++;
        if (level !== 5'd16 || ovf !== 1'b0 || fifo_oe !== 1'b1) begin
            errors++;
            $display("FAIL full_push_pop actual=lvl%0d ovf%b oe%b required=lvl16 ovf0 oe1", level, ovf, fifo_oe);
        end
        repeat (140) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_push_pop_drain edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (sent.size() != 17 || sent[16] !== 8'h3C) begin
            errors++;
            $display("FAIL full_push_pop_last actual=%0d bytes last=%h required=17 bytes last=3c",
                     sent.size(), sent.size() ? sent[sent.size()-1] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int n;
        apply_reset();
        txe_n = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            wr_en_n = 1'b0;
            wr_data = 8'($urandom_range(0, 255));
            tick();
        end
        wr_en_n = 1'b1;
        n = 0;
        while (!fifo_wr && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!fifo_wr) begin
            errors++;
            $display("FAIL rst_mid_wait actual=no_strobe required=strobe");
        end
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (fifo_wr !== 1'b0 || fifo_oe !== 1'b0 || level !== 5'd0 || run_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async actual=wr%b oe%b lvl%0d run_n%b required=wr0 oe0 lvl0 run_n1", fifo_wr, fifo_oe, level, run_n);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (10) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_after edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        txe_n = 1'b0;
        for (int i = 0; i < 900; i++) begin
            wr_en_n = (i < 700) ? ($urandom_range(0, 1) == 0) : 1'b1;
            wr_data = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) txe_n = ~txe_n;
            if (i >= 700) txe_n = 1'b0;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random edge=%0d actual=%h required=%h", edge_n, dut_vec(), exp_vec());
            end
        end
        wr_en_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_back_pressure();
        test_full_push_pop();
        test_reset_mid_strobe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ftdi_fifo_burst_wr.md
Name: ftdi_fifo_burst_wr

Overview:
Parametrised successor to the single-byte FTDI write engine. Buffers bytes from inner logic in an internal FIFO and drains them to an FT245-style async FIFO. Drains continuously while TXE# permits. Setup, strobe, hold and inter-write gap timing are set by parameters. Sits between the inner-logic producer and the FTDI data bus/WR pin.

Parameters:
DATA_W, 8, data bus width (bits)
DEPTH_LOG2, 4, internal buffer depth = 2**DEPTH_LOG2 entries
SETUP_CYC, 1, cycles data/OE driven before WR rises (1..255)
STROBE_CYC, 2, cycles WR held high (1..255)
HOLD_CYC, 1, cycles data held after WR falls (1..255)
GAP_CYC, 3, idle cycles after hold before TXE# re-sampled (2..255, must cover synchroniser latency)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
iWR_EN_n  in  1  push strobe, active-low, one byte per cycle
iWR_DATA  in  DATA_W  byte to push
oFULL_n  out  1  low when buffer holds 2**DEPTH_LOG2 entries
oEMPTY_n  out  1  low when buffer empty
oLEVEL  out  DEPTH_LOG2+1  current buffer occupancy
oOVF  out  1  sticky overflow flag, push lost
oRUN_WR_n  out  1  low whenever the FSM is not in IDLE
oDONE_WR_n  out  1  one-cycle low pulse per byte committed to FTDI
iFIFO_TXE_n  in  1  FTDI transmit-space-available, active-low, asynchronous
oFIFO_WR  out  1  FTDI write strobe; data latched on falling edge
oFIFO_DATA  out  DATA_W  FTDI data bus value
oFIFO_OE  out  1  high while the block drives the data bus

Behaviour:
- Reset (async, rst=1). Outputs take these values: oFULL_n=1, oEMPTY_n=0, oLEVEL=0, oOVF=0, oRUN_WR_n=1, oDONE_WR_n=1, oFIFO_WR=0, oFIFO_DATA=0, oFIFO_OE=0. Buffer pointers are cleared and the FSM returns to IDLE. A reset mid-write drops WR and OE immediately, and the in-flight byte is lost.
- TXE# passes through a 2-flop synchroniser (txe_s) with a reset value of 1. The FSM uses only txe_s.
- Push rule. The byte is written when iWR_EN_n=0 and (level < depth, or a pop happens in the same cycle).
  - Push while full with no pop: the data is dropped and oOVF sets until reset.
  - Push and pop in the same cycle: level is unchanged.
  - Pointers wrap modulo depth.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. One down-counter, 8 bits, is loaded on each state entry.
- IDLE → SETUP when the buffer is non-empty and txe_s=0. On that edge the head byte is popped into the output register, and oFIFO_OE rises.
- SETUP lasts SETUP_CYC cycles with WR=0, then → STROBE.
- STROBE lasts STROBE_CYC cycles with WR=1, then → HOLD. WR falls on entry to HOLD.
- HOLD lasts HOLD_CYC cycles with data and OE held. oDONE_WR_n is low for the first HOLD cycle only. Exit → GAP with OE=0.
- GAP lasts GAP_CYC cycles, then → IDLE.
- TXE# is evaluated only in IDLE. Once SETUP is entered, the byte always completes, even if TXE# rises.
- oFIFO_DATA keeps its last value outside a write.
- Per-byte period is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC+GAP_CYC cycles (8 with defaults). With txe_s already 0, the first WR rise comes 2 edges after the push edge.

Test Plan:
- Single byte, defaults, TXE#=0 settled: push 0xA5 at edge 0 → OE=1 and DATA=0xA5 from edge 1; WR=1 over edges 2–4; oDONE_WR_n low for one cycle after edge 4; OE=0 at edge 5; oRUN_WR_n high again at edge 8.
- Burst of 16 bytes 0x00..0x0F pushed back-to-back with TXE#=0 → oFULL_n never low (draining) until pushes outpace drains. Exactly 16 WR pulses, in order, spaced 8 cycles apart; oLEVEL ends at 0; oEMPTY_n=0.
- Fill 16 with TXE#=1, then push 0x55 → oFULL_n=0, oLEVEL=16, oOVF=1, 0x55 never appears on the bus. Release TXE# → 16 bytes are sent and the first WR rises 4 edges after TXE# falls.
- Back-pressure: TXE# goes high during STROBE of byte 3 → byte 3 completes, the FSM parks in IDLE with oRUN_WR_n=1, and resumes when TXE# returns low.
- Full with simultaneous push and pop in the IDLE→SETUP cycle → push accepted, oLEVEL stays 16, oOVF=0.
- Assert rst mid-STROBE → WR and OE drop immediately, oLEVEL=0, FSM idle, and no oDONE_WR_n pulse for that byte.
